// File: rtl/quad_step_decoder_if.sv
// Encoder pins in, detent step/direction/error/phase out; master drives the pins, slave is the decoder.
// Purely combinational wiring; no latency, no backpressure.
interface quad_step_decoder_if;
    logic       enc_a;
    logic       enc_b;
    logic       step;
    logic       direction;
    logic       err;
    logic [1:0] phase;

    modport master (output enc_a, enc_b, input step, direction, err, phase);
    modport slave  (input enc_a, enc_b, output step, direction, err, phase);
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: sync, debounce, Gray decode, one step pulse per detent.
// Latency: pin to phase DEBOUNCE_CYCLES+1 clocks after capture, step/err one clock later; no backpressure.
module quad_step_decoder #(
    parameter int DEBOUNCE_CYCLES  = 1000,
    parameter int DBW              = 10,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic               clk,
    input  logic               rst,
    quad_step_decoder_if.slave bus
);
    typedef enum logic [1:0] {S_INIT0, S_INIT1, S_RUN} state_t;

    localparam logic [DBW-1:0]    CNT_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [3:0] ACC_TOP  = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] ACC_BOT  = -ACC_TOP;

    state_t            state;
    state_t            state_nxt;
    logic              in_init;
    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        deb;
    logic [1:0]        deb_prev;
    logic [DBW-1:0]    cnt [2];
    logic signed [3:0] acc;
    logic signed [3:0] acc_inc;
    logic signed [3:0] acc_dec;
    logic              step_q;
    logic              err_q;
    logic              dir_q;
    logic [1:0]        idx_new;
    logic [1:0]        idx_old;
    logic [1:0]        idx_diff;

    // Bit 1 is channel A, bit 0 is channel B throughout.
    always_ff @(posedge clk) begin
        sync1 <= {bus.enc_a, bus.enc_b};
        sync2 <= sync1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT0: state_nxt = S_INIT1;
            S_INIT1: state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT0;
        endcase
    end

    always_comb begin
        in_init = (state != S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb    <= 2'b00;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else if (in_init) begin
            deb    <= sync2;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Gray to ring position; the mod-4 difference tells forward (1), reverse (3) or illegal (2).
    always_comb begin
        idx_new  = {deb[0], deb[1] ^ deb[0]};
        idx_old  = {deb_prev[0], deb_prev[1] ^ deb_prev[0]};
        idx_diff = idx_new - idx_old;
        acc_inc  = acc + 4'sd1;
        acc_dec  = acc - 4'sd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_prev <= 2'b00;
            acc      <= '0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            // While adopting, keep both copies equal so the first RUN compare sees no change.
            deb_prev <= in_init ? sync2 : deb;
            if (in_init) begin
                acc <= '0;
            end else begin
                case (idx_diff)
                    2'd1: begin
                        if (acc_inc == ACC_TOP) begin
                            step_q <= 1'b1;
                            dir_q  <= 1'b1;
                            acc    <= '0;
                        end else begin
                            acc <= acc_inc;
                        end
                    end
                    2'd3: begin
                        if (acc_dec == ACC_BOT) begin
                            step_q <= 1'b1;
                            dir_q  <= 1'b0;
                            acc    <= '0;
                        end else begin
                            acc <= acc_dec;
                        end
                    end
                    2'd2: begin
                        err_q <= 1'b1;
                        acc   <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.step      = step_q;
    assign bus.err       = err_q;
    assign bus.direction = dir_q;
    assign bus.phase     = deb;
endmodule
